// File: rtl/vec_loader.sv
// rtl/vec_loader.sv - element-pair stream to vecvecN operand loader and engine sequencer
// Optional feature macro VEC_LOADER_LAST_CHECK_EN: in_last ends a short vector (zero-filled, err_len set).
module vec_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int VECTOR_SIZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_a,
  input  logic [DATA_WIDTH-1:0]             in_b,
  input  logic                              in_last,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_a,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] vec_b,
  output logic                              dot_rst,
  input  logic                              dot_ready,
  input  logic                              dot_complete,
  input  logic [DATA_WIDTH-1:0]             dot_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_WIDTH-1:0]             res_dot,
  output logic                              err_len
);

  localparam int            CW             = $clog2(VECTOR_SIZE + 1);
  localparam logic [CW-1:0] LAST_IDX       = CW'(VECTOR_SIZE - 1);
  localparam int            UNUSED_BIN_POS = BIN_POS;

  typedef enum logic [1:0] {
    S_FILL,
    S_KICK,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_in_ready;
  logic                  r_dot_rst;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_dot;
  logic                  r_err_len;
  logic [DATA_WIDTH-1:0] r_a [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0] r_b [VECTOR_SIZE];

  logic w_accept;
  logic w_short;
  logic w_final;

  always_comb begin
    w_accept = (r_state == S_FILL) && in_valid;
`ifdef VEC_LOADER_LAST_CHECK_EN
    w_short  = in_last && (r_cnt < LAST_IDX);
`else
    w_short  = 1'b0;
`endif
    w_final  = (r_cnt == LAST_IDX) || w_short;
  end

`ifndef VEC_LOADER_LAST_CHECK_EN
  logic w_unused_last;
  assign w_unused_last = in_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_dot_rst   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_dot   <= '0;
      r_err_len   <= 1'b0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            // A short vector zero-fills the tail in the same edge so the engine sees a clean operand.
            for (int i = 0; i < VECTOR_SIZE; i++) begin
              if (i == int'(r_cnt)) begin
                r_a[i] <= in_a;
                r_b[i] <= in_b;
              end else if (w_short && (i > int'(r_cnt))) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
              end
            end
            if (w_final) begin
              r_cnt      <= '0;
              r_state    <= S_KICK;
              r_in_ready <= 1'b0;
              r_dot_rst  <= 1'b1;
              if (w_short) begin
                r_err_len <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_KICK: begin
          // Require complete low so a leftover complete from the prior run is not mistaken for this one.
          if (dot_ready && !dot_complete) begin
            r_state   <= S_WAIT;
            r_dot_rst <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dot_complete) begin
            r_res_dot   <= dot_in;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        default: begin
          r_state     <= S_FILL;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_dot_rst   <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_pack
    assign vec_a[g*DATA_WIDTH +: DATA_WIDTH] = r_a[g];
    assign vec_b[g*DATA_WIDTH +: DATA_WIDTH] = r_b[g];
  end

  assign in_ready  = r_in_ready;
  assign dot_rst   = r_dot_rst;
  assign res_valid = r_res_valid;
  assign res_dot   = r_res_dot;
  assign err_len   = r_err_len;

endmodule

// File: tb/tb_vec_loader.sv
// tb/tb_vec_loader.sv - scoreboard bench for vec_loader driving a behavioural vecvec3 engine
module tb_vec_loader;

  localparam int DW  = 32;
  localparam int VS  = 3;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic [VS*DW-1:0] vec_a;
  logic [VS*DW-1:0] vec_b;
  logic          dot_rst;
  logic          dot_ready;
  logic          dot_complete;
  logic [DW-1:0] dot_in;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_dot;
  logic          err_len;

  vec_loader #(.DATA_WIDTH(DW), .BIN_POS(16), .VECTOR_SIZE(VS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .vec_a(vec_a), .vec_b(vec_b),
    .dot_rst(dot_rst), .dot_ready(dot_ready), .dot_complete(dot_complete), .dot_in(dot_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_dot(res_dot), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dotq(input logic [VS*DW-1:0] a, input logic [VS*DW-1:0] b);
    logic signed [63:0] s;
    s = 0;
    for (int i = 0; i < VS; i++) begin
      s += $signed(a[i*DW +: DW]) * $signed(b[i*DW +: DW]);
    end
    return DW'(s >>> 16);
  endfunction

  // Behavioural engine: rst loads operands, then complete after LAT cycles, held until next rst.
  int            stale_req = 0;
  int            e_stale;
  int            e_busy;
  logic          e_prev_rst;
  logic [VS*DW-1:0] e_la;
  logic [VS*DW-1:0] e_lb;

  always @(posedge clk) begin
    e_prev_rst <= dot_rst;
    if (rst) begin
      dot_ready    <= 1'b0;
      dot_complete <= 1'b0;
      dot_in       <= '0;
      e_busy       <= 0;
      e_stale      <= 0;
    end else if (dot_rst) begin
      dot_ready <= 1'b1;
      e_busy    <= 0;
      e_la      <= vec_a;
      e_lb      <= vec_b;
      if (!e_prev_rst) begin
        if (stale_req > 0) e_stale <= stale_req - 1;
        else dot_complete <= 1'b0;
      end else if (e_stale > 0) begin
        e_stale <= e_stale - 1;
      end else begin
        dot_complete <= 1'b0;
      end
    end else if (dot_ready && !dot_complete) begin
      if (e_busy == LAT - 1) begin
        dot_complete <= 1'b1;
        dot_in       <= dotq(e_la, e_lb);
      end
      e_busy <= e_busy + 1;
    end
  end

  logic [DW-1:0] sb_q[$];
  int   n_res = 0;
  int   kick_cnt = 0;
  int   last_kick_len = 0;
  int   rst_pulses = 0;
  logic prev_drst = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!dot_rst && dot_ready && !dot_complete)
        check("operand_stable", {vec_a, vec_b}, {e_la, e_lb});
      if (dot_rst) kick_cnt++;
      if (!dot_rst && prev_drst) begin
        last_kick_len = kick_cnt;
        kick_cnt = 0;
        rst_pulses++;
      end
      prev_drst = dot_rst;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) check("res_unexpected", res_valid, 1'b0);
        else check("res_dot", res_dot, sb_q.pop_front());
        n_res++;
      end
    end else begin
      kick_cnt = 0;
      prev_drst = 1'b0;
    end
  end

  logic [DW-1:0] va [VS];
  logic [DW-1:0] vb [VS];

  task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic finish_vec();
    sb_q.push_back(dotq({va[2], va[1], va[0]}, {vb[2], vb[1], vb[0]}));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_full();
    for (int k = 0; k < VS; k++) send_one(va[k], vb[k], k == VS - 1);
    finish_vec();
  endtask

  task automatic wait_until(input int target, input bit chk_busy);
    int n;
    int bad;
    n = 0; bad = 0;
    while (n_res < target && n < 300) begin
      @(negedge clk);
      #1;
      if (chk_busy && in_ready) bad = 1;
      n++;
    end
    check("result_timeout", n_res >= target, 1'b1);
    if (chk_busy) check("in_ready_busy", bad, 0);
  endtask

  task automatic set_vec(input logic [DW-1:0] a0, a1, a2, b0, b1, b2);
    va[0] = a0; va[1] = a1; va[2] = a2;
    vb[0] = b0; vb[1] = b1; vb[2] = b2;
  endtask

  int s;
  int p0;
  int n;
  logic [DW-1:0]    h_dot;
  logic [VS*DW-1:0] h_a;
  logic [VS*DW-1:0] h_b;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {in_ready, res_valid, dot_rst, err_len, res_dot, vec_a, vec_b},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 96'h0, 96'h0});
    rst = 1'b0;

    // basic dot product
    set_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000);
    s = n_res;
    send_full();
    check("basic_vec_a", vec_a, 96'h00030000_00020000_00010000);
    check("basic_kick", {dot_rst, in_ready}, 2'b10);
    wait_until(s + 1, 1'b1);
    @(negedge clk);
    check("basic_after", {res_valid, in_ready}, 2'b01);

    // result backpressure
    res_ready = 1'b0;
    set_vec(32'h0000_8000, 32'hFFFE_0000, 32'h0001_4000, 32'h0003_0000, 32'h0001_0000, 32'hFFFC_0000);
    s = n_res;
    send_full();
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", res_valid, 1'b1);
    h_dot = res_dot; h_a = vec_a; h_b = vec_b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {res_valid, in_ready, res_dot, vec_a, vec_b}, {1'b1, 1'b0, h_dot, h_a, h_b});
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_until(s + 1, 1'b0);
    @(negedge clk);
    check("bp_release", in_ready, 1'b1);

    // back-to-back vectors
    s = n_res;
    p0 = rst_pulses;
    set_vec(32'hFFFE_8000, 32'h0000_0000, 32'h0002_0000, 32'h0002_0000, 32'h0007_0000, 32'h0000_4000);
    send_full();
    set_vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
    send_full();
    wait_until(s + 2, 1'b0);
    @(negedge clk);
    check("b2b_rst_pulses", rst_pulses - p0, 2);

    // stale complete held into KICK
    stale_req = 3;
    s = n_res;
    set_vec(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    send_full();
    wait_until(s + 1, 1'b1);
    stale_req = 0;
    check("stale_kick_len", last_kick_len, 5);

    // reset while waiting on the engine
    set_vec(32'h0003_0000, 32'h0003_0000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    send_full();
    n = 0;
    while (dot_rst && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_entry_timeout", dot_rst, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    check("midrun_reset", {in_ready, res_valid, dot_rst, err_len, res_dot, vec_a, vec_b},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 96'h0, 96'h0});
    s = n_res;
    set_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    send_full();
    wait_until(s + 1, 1'b1);

    // short vector: index 2 currently holds 3.0 in vec_a
    s = n_res;
    send_one(32'h0002_0000, 32'h0003_0000, 1'b0);
    send_one(32'h0001_0000, 32'h0001_0000, 1'b1);
`ifdef VEC_LOADER_LAST_CHECK_EN
    set_vec(32'h0002_0000, 32'h0001_0000, 32'h0000_0000, 32'h0003_0000, 32'h0001_0000, 32'h0000_0000);
    finish_vec();
    check("short_fill", {vec_a[95:64], vec_b[95:64], err_len, dot_rst}, {32'h0, 32'h0, 1'b1, 1'b1});
`else
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("short_ignored", {in_ready, dot_rst, err_len}, 3'b100);
    set_vec(32'h0002_0000, 32'h0001_0000, 32'h0004_0000, 32'h0003_0000, 32'h0001_0000, 32'h0000_8000);
    send_one(va[2], vb[2], 1'b0);
    finish_vec();
    check("third_kick", {dot_rst, err_len}, 2'b10);
`endif
    wait_until(s + 1, 1'b1);
    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
